// File: rtl/alu_divider.sv
// alu_divider: iterative restoring divider producing one quotient bit per clock.
// Optional build macro: DIV_SIGNED_EN adds the Sgn port and signed (truncating) division.
module alu_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef DIV_SIGNED_EN
  input  logic             Sgn,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Quot,
  output logic [WIDTH-1:0] Rem,
  output logic             DivZero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] rem_r, quo_r, div_r;
  logic [CNT_W-1:0] count;
  logic             neg_q, neg_r;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg_q_in, neg_r_in;
  logic [WIDTH:0]   rem_sh;
  logic             carry_low;
  logic [WIDTH-1:0] diff;
  logic             take;
  logic [WIDTH-1:0] rem_step, quo_step, quot_fix, rem_fix;
  logic             last;

`ifdef DIV_SIGNED_EN
  // Signed operands are reduced to magnitudes at acceptance; the sign flags remember the fix-up.
  always_comb begin
    mag_a    = (Sgn && A[WIDTH-1]) ? (~A + ONE) : A;
    mag_b    = (Sgn && B[WIDTH-1]) ? (~B + ONE) : B;
    neg_q_in = Sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
    neg_r_in = Sgn && A[WIDTH-1];
  end
`else
  // Unsigned build: operands are used as they are and no fix-up is needed.
  always_comb begin
    mag_a    = A;
    mag_b    = B;
    neg_q_in = 1'b0;
    neg_r_in = 1'b0;
  end
`endif

  // One restoring step: shift {R,Q} left, try R' + ~D + 1. The WIDTH+1-bit carry is the
  // shifted-out remainder MSB OR'd with the carry of the low WIDTH-bit subtraction.
  always_comb begin
    rem_sh              = {rem_r, quo_r[WIDTH-1]};
    {carry_low, diff}   = {1'b0, rem_sh[WIDTH-1:0]} + {1'b0, ~div_r} + {{WIDTH{1'b0}}, 1'b1};
    take                = rem_sh[WIDTH] | carry_low;
    rem_step            = take ? diff : rem_sh[WIDTH-1:0];
    quo_step            = {quo_r[WIDTH-2:0], take};
    quot_fix            = neg_q ? (~quo_step + ONE) : quo_step;
    rem_fix             = neg_r ? (~rem_step + ONE) : rem_step;
    last                = (count == CNT_END);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and status outputs; busy covers RUN and DONE, done only DONE.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (B != '0) ? RUN : DONE;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result/DivZero registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r   <= '0;
      quo_r   <= '0;
      div_r   <= '0;
      count   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      Quot    <= '0;
      Rem     <= '0;
      DivZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (B != '0) begin
              quo_r   <= mag_a;
              div_r   <= mag_b;
              rem_r   <= '0;
              count   <= '0;
              neg_q   <= neg_q_in;
              neg_r   <= neg_r_in;
              DivZero <= 1'b0;
            end else begin
              Quot    <= '1;
              Rem     <= A;
              DivZero <= 1'b1;
            end
          end
        end
        RUN: begin
          rem_r <= rem_step;
          quo_r <= quo_step;
          count <= count + CNT_ONE;
          if (last) begin
            Quot <= quot_fix;
            Rem  <= rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// tb_alu_divider: directed and random checks of alu_divider against an arithmetic reference.
module tb_alu_divider;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] A, B;
`ifdef DIV_SIGNED_EN
  logic             sgnIn;
`endif
  logic             busy, done, DivZero;
  logic [WIDTH-1:0] Quot, Rem;

  int vectors     = 0;
  int miscompares = 0;

  alu_divider #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .A       (A),
    .B       (B),
`ifdef DIV_SIGNED_EN
    .Sgn     (sgnIn),
`endif
    .busy    (busy),
    .done    (done),
    .Quot    (Quot),
    .Rem     (Rem),
    .DivZero (DivZero)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Reference: plain integer division; signed mode uses truncating division of 64-bit values.
  function automatic void refModel(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s, output logic [WIDTH-1:0] q,
                                   output logic [WIDTH-1:0] r);
    longint sa, sb;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = WIDTH'(sa / sb);
      r  = WIDTH'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Waits (bounded) for done; n counts cycles since the start cycle.
  task automatic waitDone(inout int n);
    while (!done && n < WIDTH + 10) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Full transaction: start pulse, operand scrambling, latency and result checks.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic s, input string tag);
    logic [WIDTH-1:0] q, r;
    int n;
    refModel(a, b, s, q, r);
    @(posedge clk); #1;
    A     = a;
    B     = b;
`ifdef DIV_SIGNED_EN
    sgnIn = s;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A     = $urandom;
    B     = $urandom;
    n     = 1;
    if (b != 0) checkOutput({tag, " busy"}, WIDTH'(busy), 32'd1);
    waitDone(n);
    checkOutput({tag, " latency"}, WIDTH'(n), (b == 0) ? 32'd1 : 32'(WIDTH + 1));
    checkOutput({tag, " quot"}, Quot, q);
    checkOutput({tag, " rem"}, Rem, r);
    checkOutput({tag, " divzero"}, WIDTH'(DivZero), WIDTH'(b == 0));
    @(posedge clk); #1;
    checkOutput({tag, " done drop"}, WIDTH'(done), 32'd0);
    checkOutput({tag, " busy drop"}, WIDTH'(busy), 32'd0);
  endtask

  // Directed sequence followed by random vectors.
  initial begin
    int n, pulses;
    logic [WIDTH-1:0] ra, rb;
    logic rs;

    reset = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
`ifdef DIV_SIGNED_EN
    sgnIn = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", WIDTH'(busy), 32'd0);
    checkOutput("reset done", WIDTH'(done), 32'd0);
    checkOutput("reset quot", Quot, 32'd0);
    checkOutput("reset rem", Rem, 32'd0);
    checkOutput("reset divzero", WIDTH'(DivZero), 32'd0);
    reset = 1'b0;

    applyStimulus(32'd100, 32'd7, 1'b0, "100/7");
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, "max/1");
    applyStimulus(32'd5, 32'hFFFF_FFFF, 1'b0, "5/max");
    applyStimulus(32'h1234, 32'd0, 1'b0, "divzero");

    // Results must hold while idle even as the operand inputs wander.
    A = 32'hDEAD_BEEF;
    B = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle hold quot", Quot, 32'hFFFF_FFFF);
    checkOutput("idle hold rem", Rem, 32'h1234);
    applyStimulus(32'd50, 32'd5, 1'b0, "divzero clear");

    // A start pulse mid-run must be ignored.
    @(posedge clk); #1;
    A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 9) begin @(posedge clk); #1; n++; end
    A = 32'd9; B = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n++;
    waitDone(n);
    checkOutput("ignored start latency", WIDTH'(n), 32'(WIDTH + 1));
    checkOutput("ignored start quot", Quot, 32'd14);
    checkOutput("ignored start rem", Rem, 32'd2);
    pulses = 0;
    repeat (WIDTH + 5) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checkOutput("ignored start extra done", WIDTH'(pulses), 32'd0);

    // Reset in the middle of an operation discards it.
    @(posedge clk); #1;
    A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("midreset busy", WIDTH'(busy), 32'd0);
    checkOutput("midreset quot", Quot, 32'd0);
    checkOutput("midreset rem", Rem, 32'd0);
    pulses = 0;
    repeat (WIDTH + 8) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checkOutput("midreset no done", WIDTH'(pulses), 32'd0);
    applyStimulus(32'd9, 32'd3, 1'b0, "after reset");

`ifdef DIV_SIGNED_EN
    applyStimulus(-32'sd7, 32'd2, 1'b1, "s -7/2");
    applyStimulus(32'd7, -32'sd2, 1'b1, "s 7/-2");
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s overflow");
    applyStimulus(32'h8000_0005, 32'd0, 1'b1, "s divzero");
`endif

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case (i % 4)
        0:       rb = $urandom;
        1:       rb = 32'($urandom_range(1, 255));
        2:       rb = ra >> $urandom_range(0, 31);
        default: rb = (i == 7) ? 32'd0 : 32'($urandom_range(1, 65535));
      endcase
`ifdef DIV_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      applyStimulus(ra, rb, rs, $sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
